noc_mem_ni: RTL

Network interface sitting between one node's `sr_mem_ctrl` and its NoC router port. The TX side accepts single-cycle 68-bit request/response packets from the memory controller, buffers them, and serializes each into a 4-flit wormhole packet with valid/ready flow control. The RX side reassembles incoming flits and delivers each packet to the memory controller as a single-cycle `validIn` pulse, gated by `readyToReceive`.

---
 rtl/noc_ni_pkg.sv | 40 ++++
 rtl/noc_ni_fifo.sv | 54 +++++
 rtl/noc_mem_ni.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/noc_ni_pkg.sv
// Shared flit encoding, head-flit field layout and FSM state types for the
// memory-controller network interface.
package noc_ni_pkg;

  localparam int FLIT_W = 34;
  localparam int PKT_W  = 68;

  localparam int HEAD_DEST_LSB = 0;
  localparam int HEAD_SRC_LSB  = 8;
  localparam int HEAD_ID_LSB   = 16;

  typedef enum logic [1:0] {
    FLIT_ILLEGAL = 2'b00,
    FLIT_HEAD    = 2'b01,
    FLIT_BODY    = 2'b10,
    FLIT_TAIL    = 2'b11
  } flit_type_e;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_HEAD,
    TX_B1,
    TX_B2,
    TX_TAIL
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_HEAD,
    RX_B1,
    RX_B2,
    RX_TAIL,
    RX_DELIVER
  } rx_state_e;

  function automatic logic [FLIT_W-1:0] make_flit(input flit_type_e t,
                                                   input logic [31:0] payload);
    return {t, payload};
  endfunction

endpackage

// File: rtl/noc_ni_fifo.sv
// Synchronous FIFO with a look-ahead port exposing the entry behind the head,
// so a consumer can preload the following packet in the same cycle it pops.
module noc_ni_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [WIDTH-1:0] next_data,
  output logic             full,
  output logic             empty,
  output logic             single
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign count   = wr_ptr - rd_ptr;
  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign single  = (count == (AW + 1)'(1));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot the push lands in.
  assign do_push = push && (!full || do_pop);

  assign head_data = mem[rd_ptr[AW-1:0]];
  assign next_data = mem[rd_ptr[AW-1:0] + AW'(1)];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW + 1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/noc_mem_ni.sv
// NoC network interface for sr_mem_ctrl: serialises 68-bit packets into
// 4-flit wormhole packets on TX and reassembles/delivers them on RX.
module noc_mem_ni
  import noc_ni_pkg::*;
#(
  parameter int NODE_ID         = 0,
  parameter int NODE_COUNT      = 8,
  parameter int PACKET_ID_WIDTH = 5,
  parameter int TX_DEPTH        = 4,
  localparam int NW = (NODE_COUNT > 1) ? $clog2(NODE_COUNT) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [PKT_W-1:0]           packetOut,
  input  logic [NW-1:0]              nodeDest,
  input  logic [PACKET_ID_WIDTH-1:0] packetId,
  input  logic                       validOut,
  output logic [PKT_W-1:0]           packetIn,
  output logic [NW-1:0]              nodeStart,
  output logic                       validIn,
  input  logic                       readyToReceive,
  output logic [FLIT_W-1:0]          flitOut,
  output logic                       flitOutValid,
  input  logic                       flitOutReady,
  input  logic [FLIT_W-1:0]          flitIn,
  input  logic                       flitInValid,
  output logic                       flitInReady,
  output logic                       txOverflow,
  output logic                       rxError
);

  localparam int ENT_W = NW + PACKET_ID_WIDTH + PKT_W;

  // ---------------------------------------------------------------- TX side
  tx_state_e        tx_state;
  logic [ENT_W-1:0] fifo_head;
  logic [ENT_W-1:0] fifo_next;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_single;
  logic             fifo_pop;
  logic             push_ok;
  logic             tx_acc;
  logic             unused_fields;

  function automatic logic [FLIT_W-1:0] head_flit(input logic [NW-1:0] dest,
                                                   input logic [PACKET_ID_WIDTH-1:0] id);
    logic [7:0] d8;
    logic [7:0] i8;
    d8 = '0;
    i8 = '0;
    d8[NW-1:0] = dest;
    i8[PACKET_ID_WIDTH-1:0] = id;
    return make_flit(FLIT_HEAD, {8'd0, i8, 8'(NODE_ID), d8});
  endfunction

  function automatic logic [FLIT_W-1:0] entry_head(input logic [ENT_W-1:0] e);
    return head_flit(e[PKT_W+PACKET_ID_WIDTH +: NW], e[PKT_W +: PACKET_ID_WIDTH]);
  endfunction

  assign tx_acc   = flitOutValid && flitOutReady;
  assign fifo_pop = tx_acc && (tx_state == TX_TAIL);
  assign push_ok  = validOut && (!fifo_full || fifo_pop);

  // Head header fields are preloaded from the look-ahead port or the inputs,
  // and only the packet payload of the look-ahead entry is never needed.
  assign unused_fields = ^{fifo_head[ENT_W-1:PKT_W], fifo_next[PKT_W-1:0]};

  noc_ni_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_ok),
    .push_data ({nodeDest, packetId, packetOut}),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .next_data (fifo_next),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .single    (fifo_single)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state     <= TX_IDLE;
      flitOut      <= '0;
      flitOutValid <= 1'b0;
      txOverflow   <= 1'b0;
    end else begin
      if (validOut && !push_ok) txOverflow <= 1'b1;
      case (tx_state)
        TX_IDLE: begin
          // Packet goes straight from the inputs into the head flit register.
          if (push_ok && fifo_empty) begin
            flitOut      <= head_flit(nodeDest, packetId);
            flitOutValid <= 1'b1;
            tx_state     <= TX_HEAD;
          end
        end
        TX_HEAD: if (tx_acc) begin
          flitOut  <= make_flit(FLIT_BODY, fifo_head[31:0]);
          tx_state <= TX_B1;
        end
        TX_B1: if (tx_acc) begin
          flitOut  <= make_flit(FLIT_BODY, fifo_head[63:32]);
          tx_state <= TX_B2;
        end
        TX_B2: if (tx_acc) begin
          flitOut  <= make_flit(FLIT_TAIL, {28'd0, fifo_head[67:64]});
          tx_state <= TX_TAIL;
        end
        TX_TAIL: if (tx_acc) begin
          if (!fifo_single) begin
            flitOut  <= entry_head(fifo_next);
            tx_state <= TX_HEAD;
          end else if (push_ok) begin
            flitOut  <= head_flit(nodeDest, packetId);
            tx_state <= TX_HEAD;
          end else begin
            flitOut      <= '0;
            flitOutValid <= 1'b0;
            tx_state     <= TX_IDLE;
          end
        end
        default: begin
          flitOutValid <= 1'b0;
          tx_state     <= TX_IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- RX side
  rx_state_e        rx_state;
  flit_type_e       rx_type;
  logic             rx_acc;
  logic             rx_local;
  logic             rx_drop;
  logic [PKT_W-1:0] rx_pkt;
  logic [NW-1:0]    rx_src;

  assign rx_type     = flit_type_e'(flitIn[33:32]);
  assign flitInReady = (rx_state != RX_DELIVER);
  assign rx_acc      = flitInValid && flitInReady;
  assign rx_local    = (flitIn[HEAD_DEST_LSB +: 8] == 8'(NODE_ID));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state  <= RX_HEAD;
      rx_drop   <= 1'b0;
      rxError   <= 1'b0;
      validIn   <= 1'b0;
      packetIn  <= '0;
      nodeStart <= '0;
    end else begin
      validIn <= 1'b0;
      if (rx_acc && rx_type == FLIT_HEAD) begin
        // A head always opens a new packet; mid-packet it also aborts the old one.
        rx_state <= RX_B1;
        rx_drop  <= !rx_local;
        if (!rx_local || rx_state != RX_HEAD) rxError <= 1'b1;
      end else begin
        case (rx_state)
          RX_HEAD: if (rx_acc) rxError <= 1'b1;
          RX_B1: if (rx_acc) begin
            if (rx_type == FLIT_BODY) rx_state <= RX_B2;
            else begin
              rxError  <= 1'b1;
              rx_state <= RX_HEAD;
            end
          end
          RX_B2: if (rx_acc) begin
            if (rx_type == FLIT_BODY) rx_state <= RX_TAIL;
            else begin
              rxError  <= 1'b1;
              rx_state <= RX_HEAD;
            end
          end
          RX_TAIL: if (rx_acc) begin
            if (rx_type == FLIT_TAIL) rx_state <= rx_drop ? RX_HEAD : RX_DELIVER;
            else begin
              rxError  <= 1'b1;
              rx_state <= RX_HEAD;
            end
          end
          RX_DELIVER: if (readyToReceive) begin
            validIn   <= 1'b1;
            packetIn  <= rx_pkt;
            nodeStart <= rx_src;
            rx_state  <= RX_HEAD;
          end
          default: rx_state <= RX_HEAD;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rx_acc) begin
      if (rx_type == FLIT_HEAD) rx_src <= flitIn[HEAD_SRC_LSB +: NW];
      if (rx_state == RX_B1 && rx_type == FLIT_BODY) rx_pkt[31:0]  <= flitIn[31:0];
      if (rx_state == RX_B2 && rx_type == FLIT_BODY) rx_pkt[63:32] <= flitIn[31:0];
      if (rx_state == RX_TAIL && rx_type == FLIT_TAIL) rx_pkt[67:64] <= flitIn[3:0];
    end
  end

endmodule
